// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter
package mem_arb_pkg;
    localparam int WORDSIZE = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester A/B handshakes plus the memory port-1 bus
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;
    logic                A_REQ, A_WE, A_ACK, A_ERR;
    logic [WORDSIZE-1:0] A_ADDR, A_DIN, A_DOUT;
    logic                B_REQ, B_WE, B_ACK, B_ERR;
    logic [WORDSIZE-1:0] B_ADDR, B_DIN, B_DOUT;
    logic [WORDSIZE-1:0] MEM_ADDR, MEM_DIN, MEM_DOUT;
    logic                MEM_WE, MEM_EN;
    modport slave (
        input  A_REQ, A_WE, A_ADDR, A_DIN, B_REQ, B_WE, B_ADDR, B_DIN, MEM_DOUT, MEM_EN,
        output A_ACK, A_ERR, A_DOUT, B_ACK, B_ERR, B_DOUT, MEM_ADDR, MEM_DIN, MEM_WE
    );
    modport master (
        output A_REQ, A_WE, A_ADDR, A_DIN, B_REQ, B_WE, B_ADDR, B_DIN, MEM_DOUT, MEM_EN,
        input  A_ACK, A_ERR, A_DOUT, B_ACK, B_ERR, B_DOUT, MEM_ADDR, MEM_DIN, MEM_WE
    );
endinterface

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin picker; the pointer only breaks ties
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic a_req,
    input  logic b_req,
    input  logic ptr,
    output logic gnt_id,
    output logic gnt_vld
);
    // a lone requester always wins; with both pending the pointer decides
    always_comb begin
        gnt_vld = a_req | b_req;
        gnt_id  = (a_req & b_req) ? ptr : (b_req ? REQ_B : REQ_A);
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises requesters A and B onto the memory read/write port
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);
    state_t              state_q, state_d;
    logic                ptr_q, ptr_d, win_q, win_d, en_q, en_d, we_q, we_d;
    logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d, a_err_q, a_err_d, b_err_q, b_err_d;
    logic [WORDSIZE-1:0] addr_q, addr_d, din_q, din_d, a_dout_q, a_dout_d, b_dout_q, b_dout_d;
    logic [WORDSIZE-1:0] rdata, a_dout, b_dout;
    logic                gnt_id, gnt_vld;

    mem_arb_rr u_rr (
        .a_req   (bus.A_REQ),
        .b_req   (bus.B_REQ),
        .ptr     (ptr_q),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    // read data is only meaningful when the address was inside the window
    assign rdata  = en_q ? bus.MEM_DOUT : '0;
    // memory output is only valid in the ack cycle, so DOUT passes it through then and holds afterwards
    assign a_dout = a_ack_q ? rdata : a_dout_q;
    assign b_dout = b_ack_q ? rdata : b_dout_q;

    // next-state: grant in IDLE, capture the window flag in ISSUE, hand back in RESP
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        en_d     = en_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        a_ack_d  = 1'b0;
        b_ack_d  = 1'b0;
        a_err_d  = 1'b0;
        b_err_d  = 1'b0;
        a_dout_d = a_dout;
        b_dout_d = b_dout;
        case (state_q)
            IDLE: if (gnt_vld) begin
                win_d   = gnt_id;
                addr_d  = (gnt_id == REQ_B) ? bus.B_ADDR : bus.A_ADDR;
                din_d   = (gnt_id == REQ_B) ? bus.B_DIN : bus.A_DIN;
                we_d    = (gnt_id == REQ_B) ? bus.B_WE : bus.A_WE;
                state_d = ISSUE;
            end
            ISSUE: begin
                en_d    = bus.MEM_EN;
                we_d    = 1'b0;
                a_ack_d = (win_q == REQ_A);
                b_ack_d = (win_q == REQ_B);
                a_err_d = (win_q == REQ_A) & ~bus.MEM_EN;
                b_err_d = (win_q == REQ_B) & ~bus.MEM_EN;
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= REQ_A;
            win_q    <= REQ_A;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            a_ack_q  <= 1'b0;
            b_ack_q  <= 1'b0;
            a_err_q  <= 1'b0;
            b_err_q  <= 1'b0;
            a_dout_q <= '0;
            b_dout_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            a_ack_q  <= a_ack_d;
            b_ack_q  <= b_ack_d;
            a_err_q  <= a_err_d;
            b_err_q  <= b_err_d;
            a_dout_q <= a_dout_d;
            b_dout_q <= b_dout_d;
        end
    end

    assign bus.MEM_ADDR = addr_q;
    assign bus.MEM_DIN  = din_q;
    assign bus.MEM_WE   = we_q;
    assign bus.A_ACK    = a_ack_q;
    assign bus.B_ACK    = b_ack_q;
    assign bus.A_ERR    = a_err_q;
    assign bus.B_ERR    = b_err_q;
    assign bus.A_DOUT   = a_dout;
    assign bus.B_DOUT   = b_dout;
endmodule
